// File: rtl/avr_fetch.sv
// -----------------------------------------------------------------------------
// avr_fetch -- instruction fetch stage for the AVR core.
//
// Purpose:
//   Master of the program flash read port. Issues word reads from a program
//   counter, absorbs the one-cycle flash read latency, recognises the 32-bit
//   opcodes (LDS/STS, JMP/CALL), assembles one- or two-word instructions and
//   hands them to decode over a valid/ready handshake. A redirect flushes
//   everything in flight and restarts fetching at the redirect target.
//
// Ports:
//   clk             in   1         single clock, all state on rising edge
//   rst             in   1         synchronous, active-high reset
//   mem_ce          out  1         flash read enable (data on mem_d next cycle,
//                                  held by the flash while mem_ce is low)
//   mem_a           out  PC_WIDTH  flash word address of the current request
//   mem_d           in   16        flash read data
//   redirect_valid  in   1         branch/jump taken: flush and refetch
//   redirect_pc     in   PC_WIDTH  redirect target word address
//   insn_valid      out  1         output instruction valid
//   insn_ready      in   1         decode accepts the instruction
//   insn_word0      out  16        opcode word
//   insn_word1      out  16        second word of a long instruction, else 0
//   insn_long       out  1         1 = 32-bit instruction
//   insn_pc         out  PC_WIDTH  word address of insn_word0
// -----------------------------------------------------------------------------
module avr_fetch #(
    parameter int                    PC_WIDTH = 10,
    parameter logic [PC_WIDTH-1:0]   RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    output logic                mem_ce,
    output logic [PC_WIDTH-1:0] mem_a,
    input  logic [15:0]         mem_d,
    input  logic                redirect_valid,
    input  logic [PC_WIDTH-1:0] redirect_pc,
    output logic                insn_valid,
    input  logic                insn_ready,
    output logic [15:0]         insn_word0,
    output logic [15:0]         insn_word1,
    output logic                insn_long,
    output logic [PC_WIDTH-1:0] insn_pc
);

    // ISSUE : first request after reset, no flash data available yet.
    // FIRST : mem_d holds the word at r_pc (an opcode word).
    // SECOND: mem_d holds the word at r_pc+1 (operand of a long opcode in r_w0).
    typedef enum logic [1:0] {
        S_ISSUE  = 2'd0,
        S_FIRST  = 2'd1,
        S_SECOND = 2'd2
    } state_t;

    localparam logic [PC_WIDTH-1:0] PC_ONE = PC_WIDTH'(1);
    localparam logic [PC_WIDTH-1:0] PC_TWO = PC_WIDTH'(2);

    state_t              r_state;
    logic [PC_WIDTH-1:0] r_pc;
    logic [15:0]         r_w0;
    logic                r_valid;
    logic [15:0]         r_word0;
    logic [15:0]         r_word1;
    logic                r_long;
    logic [PC_WIDTH-1:0] r_ipc;

    logic                w_free;
    logic                w_xfer;
    logic                w_is_long;
    logic [PC_WIDTH-1:0] w_pc_p1;
    logic [PC_WIDTH-1:0] w_pc_p2;

    // Output register can take a new instruction when empty or being drained.
    assign w_free    = !r_valid || insn_ready;
    assign w_xfer    = r_valid && insn_ready;
    assign w_is_long = ((mem_d & 16'hFC0F) == 16'h9000) ||
                       ((mem_d & 16'hFE0C) == 16'h940C);
    // Address arithmetic wraps naturally at PC_WIDTH bits.
    assign w_pc_p1   = r_pc + PC_ONE;
    assign w_pc_p2   = r_pc + PC_TWO;

    // The request must be combinational: the read issued this cycle is what
    // mem_d shows next cycle, which is what gives the two-cycle first-insn
    // latency. While mem_ce is low the flash keeps mem_d, so a stalled word
    // never needs to be re-read.
    always_comb begin
        mem_ce = 1'b0;
        mem_a  = r_pc;
        if (!rst) begin
            if (redirect_valid) begin
                mem_ce = 1'b1;
                mem_a  = redirect_pc;
            end else begin
                case (r_state)
                    S_ISSUE: begin
                        mem_ce = 1'b1;
                        mem_a  = r_pc;
                    end
                    S_FIRST: begin
                        // A long opcode fetches its operand regardless of
                        // the output stall; a short one only when it can
                        // be handed off this cycle.
                        if (w_is_long || w_free) begin
                            mem_ce = 1'b1;
                            mem_a  = w_pc_p1;
                        end
                    end
                    S_SECOND: begin
                        if (w_free) begin
                            mem_ce = 1'b1;
                            mem_a  = w_pc_p2;
                        end
                    end
                    default: begin
                        mem_ce = 1'b0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_ISSUE;
            r_pc    <= RESET_PC;
            r_w0    <= '0;
            r_valid <= 1'b0;
            r_word0 <= '0;
            r_word1 <= '0;
            r_long  <= 1'b0;
            r_ipc   <= '0;
        end else begin
            // Drained with nothing new behind it -> empty; a load below wins.
            if (w_xfer) begin
                r_valid <= 1'b0;
            end

            if (redirect_valid) begin
                // Any half-assembled or in-flight word is simply forgotten;
                // the redirect target read is already on the bus this cycle.
                r_valid <= 1'b0;
                r_pc    <= redirect_pc;
                r_state <= S_FIRST;
            end else begin
                case (r_state)
                    S_ISSUE: begin
                        r_state <= S_FIRST;
                    end
                    S_FIRST: begin
                        if (w_is_long) begin
                            r_w0    <= mem_d;
                            r_state <= S_SECOND;
                        end else if (w_free) begin
                            r_valid <= 1'b1;
                            r_word0 <= mem_d;
                            r_word1 <= '0;
                            r_long  <= 1'b0;
                            r_ipc   <= r_pc;
                            r_pc    <= w_pc_p1;
                        end
                    end
                    S_SECOND: begin
                        if (w_free) begin
                            r_valid <= 1'b1;
                            r_word0 <= r_w0;
                            r_word1 <= mem_d;
                            r_long  <= 1'b1;
                            r_ipc   <= r_pc;
                            r_pc    <= w_pc_p2;
                            r_state <= S_FIRST;
                        end
                    end
                    default: begin
                        r_state <= S_ISSUE;
                    end
                endcase
            end
        end
    end

    assign insn_valid = r_valid;
    assign insn_word0 = r_word0;
    assign insn_word1 = r_word1;
    assign insn_long  = r_long;
    assign insn_pc    = r_ipc;

endmodule

// File: tb/tb_avr_fetch.sv
module tb_avr_fetch;

    localparam int              PW    = 10;
    localparam int              DEPTH = 1 << PW;
    localparam logic [PW-1:0]   RPC   = '0;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            mem_ce;
    logic [PW-1:0]   mem_a;
    logic [15:0]     mem_d = '0;
    logic            redirect_valid = 1'b0;
    logic [PW-1:0]   redirect_pc = '0;
    logic            insn_valid;
    logic            insn_ready = 1'b1;
    logic [15:0]     insn_word0;
    logic [15:0]     insn_word1;
    logic            insn_long;
    logic [PW-1:0]   insn_pc;

    logic [15:0]     flash [0:DEPTH-1];
    logic [42:0]     fields;

    int checks   = 0;
    int failures = 0;
    int n_xfer   = 0;

    logic [PW-1:0]   m_pc = RPC;
    logic            p_rst = 1'b1;
    logic            p_redir = 1'b0;
    logic            p_valid = 1'b0;
    logic            p_ready = 1'b0;
    logic [42:0]     p_fields = '0;

    avr_fetch #(.PC_WIDTH(PW), .RESET_PC(RPC)) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_ce         (mem_ce),
        .mem_a          (mem_a),
        .mem_d          (mem_d),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .insn_valid     (insn_valid),
        .insn_ready     (insn_ready),
        .insn_word0     (insn_word0),
        .insn_word1     (insn_word1),
        .insn_long      (insn_long),
        .insn_pc        (insn_pc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_ce) mem_d <= flash[mem_a];
    end

    assign fields = {insn_word0, insn_word1, insn_long, insn_pc};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic is_long(input logic [15:0] w);
        return ((w & 16'hFC0F) == 16'h9000) || ((w & 16'hFE0C) == 16'h940C);
    endfunction

    function automatic logic [42:0] ref_insn(input logic [PW-1:0] pc);
        logic [PW-1:0] nxt;
        nxt = pc + 1'b1;
        if (is_long(flash[pc])) return {flash[pc], flash[nxt], 1'b1, pc};
        return {flash[pc], 16'h0000, 1'b0, pc};
    endfunction

    function automatic logic [PW-1:0] ref_next(input logic [PW-1:0] pc);
        return is_long(flash[pc]) ? pc + PW'(2) : pc + PW'(1);
    endfunction

    function automatic logic [15:0] gen_word();
        logic [15:0] w;
        w = 16'($urandom);
        case ($urandom_range(0, 9))
            0, 1:    w = (w & ~16'hFC0F) | 16'h9000;
            2:       w = (w & ~16'hFE0C) | 16'h940C;
            default: if (is_long(w)) w = w ^ 16'h0004;
        endcase
        return w;
    endfunction

    task automatic sample();
        @(negedge clk);
        if (rst) chk("ce_low_in_rst", mem_ce, 1'b0);
        if (p_rst || p_redir) begin
            chk("valid_cleared", insn_valid, 1'b0);
        end else if (p_valid && !p_ready) begin
            chk("stall_valid", insn_valid, 1'b1);
            chk("stall_fields", fields, p_fields);
        end
        if (!rst && insn_valid && insn_ready) begin
            chk("xfer", fields, ref_insn(m_pc));
            m_pc = ref_next(m_pc);
            n_xfer++;
        end
        if (rst) m_pc = RPC;
        else if (redirect_valid) m_pc = redirect_pc;
        p_rst    = rst;
        p_redir  = redirect_valid;
        p_valid  = insn_valid;
        p_ready  = insn_ready;
        p_fields = fields;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc();
        sample();
        adv();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        redirect_valid = 1'b0;
        cyc();
        rst = 1'b0;
    endtask

    task automatic clear_flash();
        for (int i = 0; i < DEPTH; i++) flash[i] = 16'h0000;
    endtask

    initial begin
        #1;
        clear_flash();
        insn_ready = 1'b1;
        do_reset();
        sample();
        chk("rst_valid", insn_valid, 1'b0);
        chk("rst_fields", fields, 43'h0);
        chk("c0_ce", mem_ce, 1'b1);
        chk("c0_addr", mem_a, RPC);
        adv();
        sample();
        chk("c1_valid", insn_valid, 1'b0);
        adv();
        for (int k = 2; k <= 5; k++) begin
            sample();
            chk("t1_valid", insn_valid, 1'b1);
            chk("t1_pc", insn_pc, PW'(k - 2));
            chk("t1_long", insn_long, 1'b0);
            chk("t1_word1", insn_word1, 16'h0000);
            adv();
        end

        clear_flash();
        flash[0] = 16'h940C;
        flash[1] = 16'h0010;
        do_reset();
        cyc();
        cyc();
        sample();
        chk("t2_c2_valid", insn_valid, 1'b0);
        adv();
        sample();
        chk("t2_c3_insn", {insn_valid, fields}, {1'b1, 16'h940C, 16'h0010, 1'b1, 10'h000});
        adv();
        sample();
        chk("t2_c4_pc", {insn_valid, insn_pc}, {1'b1, 10'h002});
        adv();

        clear_flash();
        do_reset();
        cyc();
        cyc();
        sample();
        chk("t3_c2_pc", insn_pc, 10'h000);
        adv();
        insn_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            sample();
            chk("t3_hold", {insn_valid, insn_pc}, {1'b1, 10'h001});
            chk("t3_ce", mem_ce, 1'b0);
            adv();
        end
        insn_ready = 1'b1;
        sample();
        chk("t3_resume1", {insn_valid, insn_pc}, {1'b1, 10'h001});
        adv();
        sample();
        chk("t3_resume2", {insn_valid, insn_pc}, {1'b1, 10'h002});
        adv();

        clear_flash();
        flash[4]      = 16'h940C;
        flash[5]      = 16'h0055;
        flash[10'h20] = 16'h1234;
        do_reset();
        for (int k = 0; k < 5; k++) cyc();
        sample();
        chk("t4_operand_req", {mem_ce, mem_a}, {1'b1, 10'h005});
        adv();
        redirect_valid = 1'b1;
        redirect_pc    = 10'h020;
        sample();
        chk("t4_redir_req", {mem_ce, mem_a}, {1'b1, 10'h020});
        adv();
        redirect_valid = 1'b0;
        sample();
        chk("t4_n1_valid", insn_valid, 1'b0);
        adv();
        sample();
        chk("t4_n2_insn", {insn_valid, fields}, {1'b1, 16'h1234, 16'h0000, 1'b0, 10'h020});
        adv();

        flash[10'h3FF] = 16'h9000;
        flash[0]       = 16'h0123;
        redirect_valid = 1'b1;
        redirect_pc    = 10'h3FF;
        sample();
        chk("t5_redir_req", mem_a, 10'h3FF);
        adv();
        redirect_valid = 1'b0;
        sample();
        chk("t5_n1_valid", insn_valid, 1'b0);
        adv();
        sample();
        chk("t5_n2_valid", insn_valid, 1'b0);
        adv();
        sample();
        chk("t5_n3_insn", {insn_valid, fields}, {1'b1, 16'h9000, 16'h0123, 1'b1, 10'h3FF});
        adv();
        sample();
        chk("t5_next_pc", {insn_valid, insn_pc}, {1'b1, 10'h001});
        adv();

        insn_ready = 1'b0;
        cyc();
        cyc();
        sample();
        chk("t6_stalled", insn_valid, 1'b1);
        adv();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        insn_ready = 1'b1;
        sample();
        chk("t6_c0_valid", insn_valid, 1'b0);
        adv();
        sample();
        chk("t6_c1_valid", insn_valid, 1'b0);
        adv();
        sample();
        chk("t6_c2_insn", {insn_valid, insn_pc}, {1'b1, RPC});
        adv();

        for (int i = 0; i < DEPTH; i++) flash[i] = gen_word();
        do_reset();
        n_xfer = 0;
        for (int k = 0; k < 3000; k++) begin
            insn_ready     = ($urandom_range(0, 3) != 0);
            rst            = ($urandom_range(0, 199) == 0);
            redirect_valid = !rst && ($urandom_range(0, 19) == 0);
            redirect_pc    = PW'($urandom);
            cyc();
        end
        rst = 1'b0;
        redirect_valid = 1'b0;
        cyc();
        chk("rand_progress", (n_xfer > 500), 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
